usb_vreq_hamming_engine: RTL and testbench
==========================================

Name: usb_vreq_hamming_engine

Overview:
Parametrised successor to the single-byte vendor-request Hamming responder in the USB top level. It captures USB vendor requests and loads two wide operands (OP_W bits) in 16-bit slices. It computes Hamming distance or popcount serially, BITS_PER_CYC bits per clock, then writes a little-endian multi-byte result into the usb2_top IN buffer and runs the commit / commit_ack handshake. It sits between usb2_top (vend_req_*, buf_in_*) and the clk_50 user logic.

Parameters:
OP_W, 64, operand width in bits; multiple of 16 and of BITS_PER_CYC; 16..256.
BITS_PER_CYC, 8, bits compared per CALC cycle; power of two, 1..OP_W.
ACK_TIMEOUT, 4096, clk_50 cycles allowed in COMMIT or WAIT_LOW before abort.
ADDR_W, 9, IN buffer address width.
LEN_W, 10, commit length width.

Ports:
clk_50  in  1  sole clock; all usb2_top status inputs are asynchronous to it.
reset  in  1  asynchronous, active-high reset.
usb_configured  in  1  usb2_top stat_configured.
vend_req_act  in  1  vendor request active level from usb2_top.
vend_req_request  in  8  bRequest code.
vend_req_val  in  16  wValue payload.
buf_in_ready  in  1  IN buffer free.
buf_in_commit_ack  in  1  commit acknowledge.
buf_in_addr  out  ADDR_W  IN buffer write address.
buf_in_data  out  8  IN buffer write data.
buf_in_wren  out  1  write strobe, one byte per cycle.
buf_in_commit  out  1  commit request.
buf_in_commit_len  out  LEN_W  committed byte count.
result  out  $clog2(OP_W+1)  last computed count, for HEX display.
busy  out  1  high whenever state is not IDLE.
err_dropped  out  1  sticky: a request edge arrived while busy or while not ready.
err_timeout  out  1  one-cycle pulse on commit handshake abort.

Behaviour:
- Reset: all outputs 0; operands A and B cleared; state IDLE. Reset mid-operation aborts immediately and never issues a commit.
- Input sync: vend_req_act, buf_in_ready, buf_in_commit_ack and usb_configured each pass through two flops. Request edge = act_s1 & ~act_s2. request and val are sampled on that edge cycle; usb2_top holds them stable while act is high.
- Edge acceptance: accepted only in IDLE with usb_configured_s & buf_in_ready_s. Any other edge sets err_dropped. err_dropped clears only on reset.
- Request codes (package constants):
  - 0x01 LEGACY: distance of val[15:8] vs val[7:0]; 1-byte response.
  - 0x10 LOAD_A: A <= {A[OP_W-17:0], val}; no response; back to IDLE next cycle.
  - 0x11 LOAD_B: same shift-in, applied to B.
  - 0x12 CLEAR: A = B = 0; no response.
  - 0x20 DIST: popcount(A^B).
  - 0x21 POPCNT: popcount(A).
  - Other codes: 1-byte response 0xEE.
- Response length: RESP_BYTES = ceil($clog2(OP_W+1)/8).
- States:
  - IDLE: waits for an accepted edge.
  - CALC: accumulates BITS_PER_CYC bits per cycle for OP_W/BITS_PER_CYC cycles; LEGACY uses 8/BITS_PER_CYC cycles, minimum 1; result updates on CALC exit.
  - WRITE: one byte per cycle, addr 0..RESP_BYTES-1, LSB first, wren high each cycle.
  - COMMIT: commit=1 and commit_len=RESP_BYTES held until ack_s=1.
  - WAIT_LOW: commit=0; returns to IDLE when ack_s=0.
- Timeout: a counter runs in COMMIT+WAIT_LOW and clears on entry. Reaching ACK_TIMEOUT pulses err_timeout, drops commit and returns to IDLE.
- Latency: edge cycle to first wren = 1 + OP_W/BITS_PER_CYC cycles for DIST.
- Boundaries:
  - Count == OP_W (all bits differ) must fit; for OP_W=64, result=64 gives byte 0x40.
  - LOAD wraps: the oldest slice is shifted out after OP_W/16 loads.
  - Simultaneous edge and busy: the request is dropped, never queued.
  - ack already high on COMMIT entry: COMMIT lasts exactly one cycle.

Decomposition:
- Package usb_vreq_pkg: request code constants, state enum, RESP_BYTES function, error byte 0xEE.
- One sub-module, popcount_slice: combinational popcount of BITS_PER_CYC bits, instantiated once inside CALC.

Test Plan:
- LEGACY, val=0xF00F, OP_W=64, BITS_PER_CYC=8 -> one wren, addr 0, data 0x08; commit_len=1; commit held until ack.
- LOAD_A x4 (0xFFFF each), CLEAR B, DIST -> data 0x40; first wren exactly 9 cycles after the synced edge.
- LOAD_A 0x00FF, 0xFF00 (upper slices 0), POPCNT -> 0x10; B unchanged.
- Second edge during CALC -> err_dropped=1; exactly one response produced.
- ack never asserted, ACK_TIMEOUT=16 -> err_timeout pulse 16 cycles after COMMIT entry; IDLE; next request is served normally.
- Reset asserted mid-WRITE -> wren and commit low at once; no commit issued; next LEGACY request gives a correct response. Also: code 0x7A -> data 0xEE, len 1.

Source files
------------

// File: rtl/usb_vreq_pkg.sv
// usb_vreq_pkg: request codes, FSM states and response sizing shared by the Hamming engine
package usb_vreq_pkg;
   localparam logic [7:0] REQ_LEGACY = 8'h01;
   localparam logic [7:0] REQ_LOAD_A = 8'h10;
   localparam logic [7:0] REQ_LOAD_B = 8'h11;
   localparam logic [7:0] REQ_CLEAR  = 8'h12;
   localparam logic [7:0] REQ_DIST   = 8'h20;
   localparam logic [7:0] REQ_POPCNT = 8'h21;
   localparam logic [7:0] ERR_BYTE   = 8'hEE;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_WRITE, S_COMMIT, S_WAIT_LOW} state_t;

   function automatic int resp_bytes(input int op_w);
      return ($clog2(op_w + 1) + 7) / 8;
   endfunction
endpackage

// File: rtl/popcount_slice.sv
// popcount_slice: combinational count of set bits in one slice
module popcount_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0]             din,
   output logic [$clog2(W+1)-1:0]   cnt
);
   localparam int CW = $clog2(W + 1);
   // adder chain over the slice bits
   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) cnt = cnt + CW'(din[i]);
   end
endmodule

// File: rtl/usb_vreq_hamming_engine.sv
// usb_vreq_hamming_engine: vendor-request driven serial Hamming distance / popcount responder
module usb_vreq_hamming_engine
   import usb_vreq_pkg::*;
#(
   parameter int OP_W         = 64,
   parameter int BITS_PER_CYC = 8,
   parameter int ACK_TIMEOUT  = 4096,
   parameter int ADDR_W       = 9,
   parameter int LEN_W        = 10
) (
   input  logic                      clk_50,
   input  logic                      reset,
   input  logic                      usb_configured,
   input  logic                      vend_req_act,
   input  logic [7:0]                vend_req_request,
   input  logic [15:0]               vend_req_val,
   input  logic                      buf_in_ready,
   input  logic                      buf_in_commit_ack,
   output logic [ADDR_W-1:0]         buf_in_addr,
   output logic [7:0]                buf_in_data,
   output logic                      buf_in_wren,
   output logic                      buf_in_commit,
   output logic [LEN_W-1:0]          buf_in_commit_len,
   output logic [$clog2(OP_W+1)-1:0] result,
   output logic                      busy,
   output logic                      err_dropped,
   output logic                      err_timeout
);
   localparam int CW   = $clog2(OP_W + 1);
   localparam int RB   = resp_bytes(OP_W);
   localparam int NCYC = OP_W / BITS_PER_CYC;
   localparam int LCYC = (8 / BITS_PER_CYC) > 0 ? 8 / BITS_PER_CYC : 1;
   localparam int PW   = $clog2(BITS_PER_CYC + 1);
   localparam int KW   = $clog2(NCYC + 1);
   localparam int TW   = $clog2(ACK_TIMEOUT + 1);
   localparam int BW   = $clog2(RB + 1);

   state_t            state, state_n;
   logic              act_s1, act_s2, rdy_s1, rdy_s2, ack_s1, ack_s2, cfg_s1, cfg_s2;
   logic [OP_W-1:0]   op_a, op_b, sh;
   logic [CW-1:0]     acc;
   logic [KW-1:0]     cnt;
   logic [BW-1:0]     widx, rlen;
   logic [TW-1:0]     tcnt;
   logic              err_resp;
   logic [PW-1:0]     pc;
   logic [RB*8-1:0]   res_ext;
   logic              req_edge, accept, calc_req, no_resp, tmo, in_hs;

   assign req_edge = act_s1 & ~act_s2;
   assign accept   = req_edge & (state == S_IDLE) & cfg_s2 & rdy_s2;
   assign calc_req = vend_req_request inside {REQ_LEGACY, REQ_DIST, REQ_POPCNT};
   assign no_resp  = vend_req_request inside {REQ_LOAD_A, REQ_LOAD_B, REQ_CLEAR};
   assign in_hs    = (state == S_COMMIT) | (state == S_WAIT_LOW);
   assign tmo      = in_hs & (tcnt == TW'(ACK_TIMEOUT - 1));
   assign busy     = state != S_IDLE;
   assign res_ext  = (RB*8)'(result);

   popcount_slice #(.W(BITS_PER_CYC)) u_pc (.din(sh[BITS_PER_CYC-1:0]), .cnt(pc));

   // state register; async reset drops any transfer in flight
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // next state and IN-buffer strobes
   always_comb begin
      state_n           = state;
      buf_in_wren       = 1'b0;
      buf_in_commit     = 1'b0;
      buf_in_commit_len = '0;
      buf_in_addr       = '0;
      buf_in_data       = '0;
      case (state)
         S_IDLE:     if (accept) state_n = calc_req ? S_CALC : (no_resp ? S_IDLE : S_WRITE);
         S_CALC:     if (cnt == '0) state_n = S_WRITE;
         S_WRITE: begin
            buf_in_wren = 1'b1;
            buf_in_addr = ADDR_W'(widx);
            buf_in_data = err_resp ? ERR_BYTE : 8'(res_ext >> {widx, 3'b000});
            if (widx == rlen - 1'b1) state_n = S_COMMIT;
         end
         S_COMMIT: begin
            buf_in_commit     = 1'b1;
            buf_in_commit_len = LEN_W'(rlen);
            state_n           = tmo ? S_IDLE : (ack_s2 ? S_WAIT_LOW : S_COMMIT);
         end
         S_WAIT_LOW: if (tmo || !ack_s2) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   // synchronisers, operand registers, serial accumulator and handshake timer
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         {act_s1, act_s2, rdy_s1, rdy_s2, ack_s1, ack_s2, cfg_s1, cfg_s2} <= '0;
         op_a        <= '0;
         op_b        <= '0;
         sh          <= '0;
         acc         <= '0;
         cnt         <= '0;
         widx        <= '0;
         rlen        <= '0;
         tcnt        <= '0;
         err_resp    <= 1'b0;
         result      <= '0;
         err_dropped <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         {act_s1, act_s2} <= {vend_req_act, act_s1};
         {rdy_s1, rdy_s2} <= {buf_in_ready, rdy_s1};
         {ack_s1, ack_s2} <= {buf_in_commit_ack, ack_s1};
         {cfg_s1, cfg_s2} <= {usb_configured, cfg_s1};
         err_timeout      <= tmo;
         tcnt             <= in_hs ? tcnt + 1'b1 : '0;
         if (req_edge && !accept) err_dropped <= 1'b1;
         if (accept) begin
            acc      <= '0;
            widx     <= '0;
            err_resp <= 1'b0;
            rlen     <= BW'(1);
            case (vend_req_request)
               REQ_LOAD_A: op_a <= OP_W'({op_a, vend_req_val});
               REQ_LOAD_B: op_b <= OP_W'({op_b, vend_req_val});
               REQ_CLEAR: begin
                  op_a <= '0;
                  op_b <= '0;
               end
               REQ_LEGACY: begin
                  sh  <= OP_W'(vend_req_val[15:8] ^ vend_req_val[7:0]);
                  cnt <= KW'(LCYC - 1);
               end
               REQ_DIST: begin
                  sh   <= op_a ^ op_b;
                  cnt  <= KW'(NCYC - 1);
                  rlen <= BW'(RB);
               end
               REQ_POPCNT: begin
                  sh   <= op_a;
                  cnt  <= KW'(NCYC - 1);
                  rlen <= BW'(RB);
               end
               default: err_resp <= 1'b1;
            endcase
         end
         if (state == S_CALC) begin
            acc <= acc + CW'(pc);
            sh  <= sh >> BITS_PER_CYC;
            cnt <= cnt - 1'b1;
            if (cnt == '0) result <= acc + CW'(pc);
         end
         if (state == S_WRITE) widx <= widx + 1'b1;
      end
   end
endmodule

// File: tb/tb_usb_vreq_hamming_engine.sv
// tb_usb_vreq_hamming_engine: table-driven scoreboard bench for the vendor-request Hamming engine
module tb_usb_vreq_hamming_engine;
   localparam logic [7:0] C_LEG = 8'h01, C_LA = 8'h10, C_LB = 8'h11, C_CLR = 8'h12;
   localparam logic [7:0] C_DIST = 8'h20, C_POP = 8'h21, C_BAD = 8'h7A;

   typedef struct {
      logic [7:0]  code;
      logic [15:0] val;
      logic        resp;
      logic [7:0]  exp;
      int          lat;
   } vec_t;

   logic        clk_50 = 1'b0;
   logic        reset, usb_configured, vend_req_act, buf_in_ready, buf_in_commit_ack;
   logic [7:0]  vend_req_request;
   logic [15:0] vend_req_val;
   logic [8:0]  buf_in_addr;
   logic [7:0]  buf_in_data;
   logic        buf_in_wren, buf_in_commit, busy, err_dropped, err_timeout;
   logic [9:0]  buf_in_commit_len;
   logic [6:0]  result;

   int          nvec = 0, nfail = 0, nwr = 0, ncommit = 0;
   logic        mon_en = 1'b1, ack_en = 1'b1, commit_q = 1'b0;
   logic [7:0]  exp_q[$];
   vec_t        tbl[30];

   usb_vreq_hamming_engine #(.OP_W(64), .BITS_PER_CYC(8), .ACK_TIMEOUT(16), .ADDR_W(9), .LEN_W(10)) dut (
      .clk_50(clk_50), .reset(reset), .usb_configured(usb_configured),
      .vend_req_act(vend_req_act), .vend_req_request(vend_req_request), .vend_req_val(vend_req_val),
      .buf_in_ready(buf_in_ready), .buf_in_commit_ack(buf_in_commit_ack),
      .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
      .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len), .result(result),
      .busy(busy), .err_dropped(err_dropped), .err_timeout(err_timeout)
   );

   always #10 clk_50 = ~clk_50;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
      end
   endtask

   // host side acknowledges whatever commit it sees, unless disabled
   always @(negedge clk_50) buf_in_commit_ack = ack_en & buf_in_commit;

   // scoreboard: every written byte and every commit rise is matched against expectations
   always @(negedge clk_50) begin
      if (buf_in_wren && mon_en) begin
         nwr++;
         if (exp_q.size() == 0) chk("unexpected_wren", 1, 0);
         else begin
            chk("wr_data", buf_in_data, exp_q.pop_front());
            chk("wr_addr", buf_in_addr, 0);
         end
      end
      if (buf_in_commit && !commit_q) begin
         ncommit++;
         if (mon_en) chk("commit_len", buf_in_commit_len, 1);
      end
      commit_q = buf_in_commit;
   end

   task automatic send(input logic [7:0] code, input logic [15:0] val, input logic resp,
                       input logic [7:0] exp, input bit dbl, output int lat, output int kc, output int kt);
      if (resp) exp_q.push_back(exp);
      @(negedge clk_50);
      vend_req_request = code;
      vend_req_val     = val;
      vend_req_act     = 1'b1;
      lat = -1; kc = -1; kt = -1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk_50);
         if (k == (dbl ? 2 : 3)) vend_req_act = 1'b0;
         if (dbl && k == 4) vend_req_act = 1'b1;
         if (dbl && k == 6) vend_req_act = 1'b0;
         if (buf_in_wren && lat < 0) lat = k;
         if (buf_in_commit && kc < 0) kc = k;
         if (err_timeout && kt < 0) kt = k;
         if (k > 6 && !busy) break;
      end
      chk("back_to_idle", busy, 0);
      repeat (3) @(negedge clk_50);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int lat, kc, kt, nw0, nc0;
      tbl[0]  = '{C_LEG,  16'hF00F, 1'b1, 8'h08, 3};
      tbl[1]  = '{C_CLR,  16'h0000, 1'b0, 8'h00, 0};
      tbl[2]  = '{C_LA,   16'hFFFF, 1'b0, 8'h00, 0};
      tbl[3]  = '{C_LA,   16'hFFFF, 1'b0, 8'h00, 0};
      tbl[4]  = '{C_LA,   16'hFFFF, 1'b0, 8'h00, 0};
      tbl[5]  = '{C_LA,   16'hFFFF, 1'b0, 8'h00, 0};
      tbl[6]  = '{C_DIST, 16'h0000, 1'b1, 8'h40, 10};
      tbl[7]  = '{C_POP,  16'h0000, 1'b1, 8'h40, 10};
      tbl[8]  = '{C_LB,   16'h0001, 1'b0, 8'h00, 0};
      tbl[9]  = '{C_DIST, 16'h0000, 1'b1, 8'h3F, 10};
      tbl[10] = '{C_CLR,  16'h0000, 1'b0, 8'h00, 0};
      tbl[11] = '{C_LB,   16'h1234, 1'b0, 8'h00, 0};
      tbl[12] = '{C_LA,   16'h00FF, 1'b0, 8'h00, 0};
      tbl[13] = '{C_LA,   16'hFF00, 1'b0, 8'h00, 0};
      tbl[14] = '{C_POP,  16'h0000, 1'b1, 8'h10, 10};
      tbl[15] = '{C_DIST, 16'h0000, 1'b1, 8'h11, 10};
      tbl[16] = '{C_CLR,  16'h0000, 1'b0, 8'h00, 0};
      tbl[17] = '{C_LA,   16'h0007, 1'b0, 8'h00, 0};
      tbl[18] = '{C_LA,   16'h0001, 1'b0, 8'h00, 0};
      tbl[19] = '{C_LA,   16'h0001, 1'b0, 8'h00, 0};
      tbl[20] = '{C_LA,   16'h0001, 1'b0, 8'h00, 0};
      tbl[21] = '{C_LA,   16'h0003, 1'b0, 8'h00, 0};
      tbl[22] = '{C_POP,  16'h0000, 1'b1, 8'h05, 10};
      tbl[23] = '{C_BAD,  16'h1234, 1'b1, 8'hEE, 0};
      tbl[24] = '{C_LEG,  16'h0000, 1'b1, 8'h00, 3};
      tbl[25] = '{C_LEG,  16'h1302, 1'b1, 8'h02, 3};
      tbl[26] = '{C_CLR,  16'h0000, 1'b0, 8'h00, 0};
      tbl[27] = '{C_LA,   16'h5A5A, 1'b0, 8'h00, 0};
      tbl[28] = '{C_LB,   16'h5A5A, 1'b0, 8'h00, 0};
      tbl[29] = '{C_DIST, 16'h0000, 1'b1, 8'h00, 10};

      reset = 1'b1; usb_configured = 1'b1; buf_in_ready = 1'b1; buf_in_commit_ack = 1'b0;
      vend_req_act = 1'b0; vend_req_request = '0; vend_req_val = '0;
      repeat (3) @(negedge clk_50);
      chk("rst_wren", buf_in_wren, 0);
      chk("rst_commit", buf_in_commit, 0);
      chk("rst_addr_data_len", {buf_in_addr, buf_in_data, buf_in_commit_len}, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {busy, err_dropped, err_timeout}, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk_50);

      foreach (tbl[i]) begin
         send(tbl[i].code, tbl[i].val, tbl[i].resp, tbl[i].exp, 1'b0, lat, kc, kt);
         if (tbl[i].resp) begin
            chk("no_timeout", kt, -1);
            if (tbl[i].lat > 0) chk("latency", lat, tbl[i].lat);
            if (tbl[i].exp != 8'hEE) chk("result", result, tbl[i].exp);
         end
      end

      // second edge arrives during CALC and must be dropped
      chk("dropped_clear", err_dropped, 0);
      nw0 = nwr;
      send(C_DIST, 16'h0000, 1'b1, 8'h00, 1'b1, lat, kc, kt);
      chk("dropped_set", err_dropped, 1);
      chk("dropped_one_resp", nwr - nw0, 1);

      // host never acknowledges: handshake aborts after 16 cycles
      ack_en = 1'b0;
      send(C_LEG, 16'hF00F, 1'b1, 8'h08, 1'b0, lat, kc, kt);
      chk("tmo_commit_seen", kc > 0, 1);
      chk("tmo_delay", kt - kc, 16);
      ack_en = 1'b1;
      send(C_LEG, 16'hAA55, 1'b1, 8'h08, 1'b0, lat, kc, kt);
      chk("after_tmo_no_timeout", kt, -1);
      chk("after_tmo_result", result, 8);

      // reset lands in the WRITE cycle of a DIST
      mon_en = 1'b0;
      @(negedge clk_50);
      vend_req_request = C_DIST;
      vend_req_act = 1'b1;
      repeat (10) @(negedge clk_50);
      chk("pre_reset_wren", buf_in_wren, 1);
      reset = 1'b1;
      #1;
      chk("reset_wren_low", buf_in_wren, 0);
      chk("reset_commit_low", buf_in_commit, 0);
      chk("reset_busy_low", busy, 0);
      nc0 = ncommit;
      vend_req_act = 1'b0;
      repeat (2) @(negedge clk_50);
      reset = 1'b0;
      repeat (20) @(negedge clk_50);
      chk("reset_no_commit", ncommit - nc0, 0);
      chk("reset_clears_dropped", err_dropped, 0);
      chk("reset_clears_result", result, 0);
      mon_en = 1'b1;
      send(C_LEG, 16'hF00F, 1'b1, 8'h08, 1'b0, lat, kc, kt);
      chk("post_reset_latency", lat, 3);
      send(C_BAD, 16'h0000, 1'b1, 8'hEE, 1'b0, lat, kc, kt);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
